// File: rtl/adder_test_ctrl.sv
// rtl/adder_test_ctrl.sv - LFSR-driven self-test sequencer for the 8-bit prefix adder
module adder_test_ctrl #(
   parameter int          CNT_W        = 16,
   parameter int          SETTLE_W     = 4,
   parameter logic [15:0] LFSR_DEFAULT = 16'hACE1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [CNT_W-1:0]    num_vectors,
   input  logic [SETTLE_W-1:0] settle_cycles,
   input  logic [15:0]         seed,
   output logic [7:0]          a_in,
   output logic [7:0]          b_in,
   input  logic [7:0]          sum,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    vec_count,
   output logic [CNT_W-1:0]    err_count,
   output logic                fail_seen,
   output logic [7:0]          fail_a,
   output logic [7:0]          fail_b,
   output logic [7:0]          fail_sum
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_APPLY  = 3'd1,
      S_SETTLE = 3'd2,
      S_CHECK  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         lfsr_q, lfsr_d;
   logic [CNT_W-1:0]    nvec_q, nvec_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [SETTLE_W-1:0] cnt_q, cnt_d;
   logic [7:0]          a_q, a_d;
   logic [7:0]          b_q, b_d;
   logic [CNT_W-1:0]    vec_q, vec_d;
   logic [CNT_W-1:0]    err_q, err_d;
   logic                fseen_q, fseen_d;
   logic [7:0]          fa_q, fa_d;
   logic [7:0]          fb_q, fb_d;
   logic [7:0]          fs_q, fs_d;

   logic [15:0]         lfsr_next;
   logic [7:0]          exp_sum;
   logic [CNT_W-1:0]    vec_inc;

   // Fibonacci LFSR step, behavioural reference sum and the next vector count
   assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign exp_sum   = a_q + b_q;
   assign vec_inc   = vec_q + CNT_W'(1);

   // State register and datapath registers; reset clears everything including the LFSR
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         lfsr_q   <= '0;
         nvec_q   <= '0;
         settle_q <= '0;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         vec_q    <= '0;
         err_q    <= '0;
         fseen_q  <= 1'b0;
         fa_q     <= '0;
         fb_q     <= '0;
         fs_q     <= '0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         nvec_q   <= nvec_d;
         settle_q <= settle_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         vec_q    <= vec_d;
         err_q    <= err_d;
         fseen_q  <= fseen_d;
         fa_q     <= fa_d;
         fb_q     <= fb_d;
         fs_q     <= fs_d;
      end
   end

   // Next-state and datapath updates; abort preempts every busy-state action
   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      nvec_d   = nvec_q;
      settle_d = settle_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      vec_d    = vec_q;
      err_d    = err_q;
      fseen_d  = fseen_q;
      fa_d     = fa_q;
      fb_d     = fb_q;
      fs_d     = fs_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               nvec_d   = num_vectors;
               settle_d = settle_cycles;
               lfsr_d   = (seed == 16'h0000) ? LFSR_DEFAULT : seed;
               vec_d    = '0;
               err_d    = '0;
               fseen_d  = 1'b0;
               fa_d     = '0;
               fb_d     = '0;
               fs_d     = '0;
               state_d  = (num_vectors == '0) ? S_DONE : S_APPLY;
            end
         end
         S_APPLY: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               a_d     = lfsr_q[7:0];
               b_d     = lfsr_q[15:8];
               cnt_d   = settle_q;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q - SETTLE_W'(1);
            end
         end
         S_CHECK: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               if (sum != exp_sum) begin
                  if (!(&err_q)) begin
                     err_d = err_q + CNT_W'(1);
                  end
                  if (!fseen_q) begin
                     fseen_d = 1'b1;
                     fa_d    = a_q;
                     fb_d    = b_q;
                     fs_d    = sum;
                  end
               end
               vec_d   = vec_inc;
               lfsr_d  = lfsr_next;
               state_d = (vec_inc == nvec_q) ? S_DONE : S_APPLY;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign a_in      = a_q;
   assign b_in      = b_q;
   assign busy      = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CHECK);
   assign done      = (state_q == S_DONE);
   assign vec_count = vec_q;
   assign err_count = err_q;
   assign fail_seen = fseen_q;
   assign fail_a    = fa_q;
   assign fail_b    = fb_q;
   assign fail_sum  = fs_q;

endmodule
